keypad_scanner: RTL and testbench

Matrix keypad front end for the Pong player controls. Drives five active-low column lines and reads three active-low row lines, scanning one column at a time. Row samples are synchronised, keys are debounced over consecutive full scans, and the result is a 4-bit key code with one-cycle press/release pulses. It sits directly upstream of the player movement logic, which consumes `key_code` and the pulses.

---
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_keypad_scanner.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 5x3 matrix keypad scanner with debounce and press/release pulses
// Optional: KEYSCAN_MULTIKEY_REJECT_EN treats scans with more than one low row as invalid.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wire1,
    input  logic       wire2,
    input  logic       wire3,
    output logic       wire4,
    output logic       wire5,
    output logic       wire6,
    output logic       wire7,
    output logic       wire8,
    output logic [3:0] key_code,
    output logic       key_down,
    output logic       key_press,
    output logic       key_release
);

    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    c;
    logic [SW-1:0] s;
    logic [4:0]    cols;
    logic [3:0]    best;
    logic [3:0]    prev;
    logic [3:0]    acc;
    logic [3:0]    stable_cnt;
    logic          scan_done;

    logic [3:0] base;
    logic [3:0] col_code;
    logic [3:0] scan_res;
    logic       sample;
    logic       scan_end;

    assign {wire8, wire7, wire6, wire5, wire4} = cols;

    always_comb begin
        base     = {1'b0, c} * 4'd3;
        col_code = 4'd0;
        if (!sync2[0])
            col_code = base + 4'd1;
        else if (!sync2[1])
            col_code = base + 4'd2;
        else if (!sync2[2])
            col_code = base + 4'd3;
        // Columns are visited in ascending order, so the first hit is the lowest code.
        scan_res = (best != 4'd0) ? best : col_code;
        sample   = (s == S_LAST);
        scan_end = sample && (c == 3'd4);
    end

`ifdef KEYSCAN_MULTIKEY_REJECT_EN
    logic [1:0] hits;
    logic [1:0] col_hits;
    logic [2:0] hit_sum;
    logic [1:0] hits_next;

    always_comb begin
        col_hits  = 2'(!sync2[0]) + 2'(!sync2[1]) + 2'(!sync2[2]);
        hit_sum   = {1'b0, hits} + {1'b0, col_hits};
        hits_next = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 3'b000;
            sync2       <= 3'b000;
            c           <= 3'd0;
            s           <= '0;
            cols        <= 5'b11110;
            best        <= 4'd0;
            prev        <= 4'd0;
            acc         <= 4'd0;
            stable_cnt  <= 4'd0;
            scan_done   <= 1'b0;
            key_code    <= 4'd0;
            key_down    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEYSCAN_MULTIKEY_REJECT_EN
            hits        <= 2'd0;
`endif
        end else begin
            sync1       <= {wire3, wire2, wire1};
            sync2       <= sync1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            scan_done   <= scan_end;

            if (sample) begin
                s    <= '0;
                c    <= (c == 3'd4) ? 3'd0 : c + 3'd1;
                cols <= {cols[3:0], cols[4]};
                if (scan_end) begin
                    best <= 4'd0;
`ifdef KEYSCAN_MULTIKEY_REJECT_EN
                    hits <= 2'd0;
                    if (hits_next > 2'd1) begin
                        stable_cnt <= 4'd0;
                        prev       <= 4'hF;
                    end else
`endif
                    if (scan_res == prev) begin
                        stable_cnt <= (stable_cnt >= DEB) ? DEB : stable_cnt + 4'd1;
                    end else begin
                        prev       <= scan_res;
                        stable_cnt <= 4'd1;
                    end
                end else begin
                    best <= scan_res;
`ifdef KEYSCAN_MULTIKEY_REJECT_EN
                    hits <= hits_next;
`endif
                end
            end else begin
                s <= s + SW'(1);
            end

            // Acceptance runs one cycle after the scan end so outputs see the settled debounce state.
            if (scan_done && (stable_cnt == DEB) && (prev != acc)) begin
                acc <= prev;
                if (prev != 4'd0) begin
                    key_code  <= prev;
                    key_down  <= 1'b1;
                    key_press <= 1'b1;
                end else begin
                    key_down    <= 1'b0;
                    key_release <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner with a matrix model
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wire1, wire2, wire3;
    logic       wire4, wire5, wire6, wire7, wire8;
    logic [3:0] key_code;
    logic       key_down, key_press, key_release;

    logic [14:0] keys = '0;   // bit (code-1) set means key pressed
    logic [4:0]  cols;

    int n_checks = 0;
    int n_pass   = 0;
    int press_cnt = 0;
    int release_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    keypad_scanner dut (
        .clk(clk), .rst(rst),
        .wire1(wire1), .wire2(wire2), .wire3(wire3),
        .wire4(wire4), .wire5(wire5), .wire6(wire6), .wire7(wire7), .wire8(wire8),
        .key_code(key_code), .key_down(key_down),
        .key_press(key_press), .key_release(key_release)
    );

    assign cols = {wire8, wire7, wire6, wire5, wire4};

    always_comb begin
        logic [2:0] r;
        r = 3'b111;
        for (int cc = 0; cc < 5; cc++)
            for (int rr = 0; rr < 3; rr++)
                if (!cols[cc] && keys[3*cc+rr]) r[rr] = 1'b0;
        {wire3, wire2, wire1} = r;
    end

    always @(negedge clk) begin
        if (key_press) press_cnt++;
        if (key_release) release_cnt++;
        if (key_press && key_release) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic clr_cnt();
        press_cnt = 0;
        release_cnt = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_code"}, key_code, 0);
        check({tag, "_down"}, key_down, 0);
    endtask

    initial begin
        // Reset values and first column step
        rst = 1'b1;
        cyc(2);
        check("rst_cols", cols, 5'b11110);
        check("rst_outs", {key_code, key_down, key_press, key_release}, 0);
        rst = 1'b0;
        cyc(15);
        check("wire5_before", wire5, 1);
        cyc(1);
        check("wire5_low", wire5, 0);
        check("wire4_high", wire4, 1);

        // Single key 8 press and release
        clr_cnt();
        keys = 15'b1 << 7;
        cyc(405);
        check("single_press_cnt", press_cnt, 1);
        check("single_code", key_code, 8);
        check("single_down", key_down, 1);
        clr_cnt();
        keys = '0;
        cyc(405);
        check("single_release_cnt", release_cnt, 1);
        check("single_nopress", press_cnt, 0);
        check("single_rel_down", key_down, 0);
        check("single_rel_code", key_code, 8);

        // Bounce: held for only two scans
        do_reset();
        clr_cnt();
        keys = 15'b1 << 7;
        cyc(160);
        keys = '0;
        cyc(500);
        check("bounce_press", press_cnt, 0);
        check("bounce_release", release_cnt, 0);
        check_idle("bounce");

        // Direct change 5 -> 9
        do_reset();
        clr_cnt();
        keys = 15'b1 << 4;
        cyc(405);
        check("chg_press5", press_cnt, 1);
        check("chg_code5", key_code, 5);
        clr_cnt();
        keys = 15'b1 << 8;
        cyc(405);
        check("chg_press9", press_cnt, 1);
        check("chg_release", release_cnt, 0);
        check("chg_code9", key_code, 9);
        check("chg_down", key_down, 1);

        // Two keys 2 and 14 together
        do_reset();
        clr_cnt();
        keys = (15'b1 << 1) | (15'b1 << 13);
        cyc(800);
`ifdef KEYSCAN_MULTIKEY_REJECT_EN
        check("multi_press", press_cnt, 0);
        check_idle("multi");
`else
        check("multi_press", press_cnt, 1);
        check("multi_code", key_code, 2);
        check("multi_down", key_down, 1);
`endif
        keys = '0;

        // Reset during the third stable scan of key 8
        do_reset();
        clr_cnt();
        keys = 15'b1 << 7;
        cyc(200);
        do_reset();
        check("mid_rst_press", press_cnt, 0);
        check("mid_rst_release", release_cnt, 0);
        check_idle("mid_rst");
        check("mid_rst_cols", cols, 5'b11110);
        cyc(405);
        check("mid_rst_fresh_press", press_cnt, 1);
        check("mid_rst_fresh_code", key_code, 8);
        keys = '0;

        check("pulses_exclusive", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
